fetch_queue_issue: RTL and testbench

Parametrised fetch stage that decouples PC generation from instruction issue. Issues sequential or redirected fetch requests to the instruction memory over a ready/valid handshake, with up to QUEUE_DEPTH requests outstanding. Buffers returned instructions with their PCs in an in-order queue. Presents them to decode through a valid/ready issue port and squashes wrong-path responses after a redirect. Sits between the core's branch/redirect logic and decode, replacing the single-register PC fetch stage.

---
 rtl/fetch_queue_issue_if.sv | 42 ++++
 rtl/fetch_queue_issue.sv | 127 ++++++++++++
 tb/tb_fetch_queue_issue.sv | 299 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_queue_issue_if.sv
// fetch_queue_issue_if
//   Bundles the redirect input, the instruction-memory request/response
//   handshake and the decode issue port of the fetch stage.
//   master : fetch stage view (drives requests and the issue port)
//   slave  : environment view (core redirect logic, memory, decode)
// Signals:
//   redirect_valid/redirect_PC             restart fetch at a new PC
//   i_mem_read/i_mem_read_address          fetch request, valid/address
//   i_mem_ready                            memory accepts the request
//   i_mem_valid/i_mem_data                 in-order instruction response
//   issue_valid/issue_PC/issue_instruction head entry offered to decode
//   issue_ready                            decode takes the head entry
interface fetch_queue_issue_if #(
   parameter int unsigned ADDRESS_BITS = 32,
   parameter int unsigned DATA_WIDTH   = 32
);
   logic                    redirect_valid;
   logic [ADDRESS_BITS-1:0] redirect_PC;
   logic                    i_mem_read;
   logic [ADDRESS_BITS-1:0] i_mem_read_address;
   logic                    i_mem_ready;
   logic                    i_mem_valid;
   logic [DATA_WIDTH-1:0]   i_mem_data;
   logic                    issue_valid;
   logic [ADDRESS_BITS-1:0] issue_PC;
   logic [DATA_WIDTH-1:0]   issue_instruction;
   logic                    issue_ready;

   modport master (
      input  redirect_valid, redirect_PC, i_mem_ready, i_mem_valid,
             i_mem_data, issue_ready,
      output i_mem_read, i_mem_read_address, issue_valid, issue_PC,
             issue_instruction
   );

   modport slave (
      output redirect_valid, redirect_PC, i_mem_ready, i_mem_valid,
             i_mem_data, issue_ready,
      input  i_mem_read, i_mem_read_address, issue_valid, issue_PC,
             issue_instruction
   );
endinterface

// File: rtl/fetch_queue_issue.sv
// fetch_queue_issue
//   Fetch stage decoupling PC generation from issue. Sends sequential or
//   redirected requests to instruction memory with at most QUEUE_DEPTH
//   requests outstanding-or-buffered, stores returned instructions with
//   their PCs in an in-order queue and offers the head to decode. Responses
//   to requests made before a redirect are discarded as they return.
// Ports:
//   clock  : system clock
//   reset  : synchronous, active-high reset
//   scan   : debug strobe, no functional effect
//   bus    : fetch_queue_issue_if.master (redirect, memory, issue port)
module fetch_queue_issue #(
   parameter int unsigned             ADDRESS_BITS = 32,
   parameter int unsigned             DATA_WIDTH   = 32,
   parameter int unsigned             QUEUE_DEPTH  = 4,
   parameter logic [ADDRESS_BITS-1:0] RESET_PC     = '0
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic                 scan,
   fetch_queue_issue_if.master  bus
);
   localparam int unsigned CW = $clog2(QUEUE_DEPTH) + 1;
   localparam int unsigned PW = $clog2(QUEUE_DEPTH);
   localparam logic [CW:0] DEPTH_LIM = QUEUE_DEPTH[CW:0];

   logic [ADDRESS_BITS-1:0] fetch_pc_q, fetch_pc_d;
   logic [ADDRESS_BITS-1:0] resp_pc_q, resp_pc_d;
   logic [CW-1:0]           inflight_q, inflight_d;
   logic [CW-1:0]           drop_count_q, drop_count_d;
   logic [CW-1:0]           count_q, count_d;
   logic [PW-1:0]           head_q, head_d;
   logic [PW-1:0]           tail_q, tail_d;

   logic [ADDRESS_BITS-1:0] pc_mem  [QUEUE_DEPTH];
   logic [DATA_WIDTH-1:0]   ins_mem [QUEUE_DEPTH];

   logic [CW:0]             occupancy;
   logic [ADDRESS_BITS-1:0] redirect_target;
   logic                    req, accept, resp, push, pop, ivalid;
   logic                    unused_bits;

   assign unused_bits = ^{scan, bus.redirect_PC[1:0]};

   always_comb begin
      redirect_target = {bus.redirect_PC[ADDRESS_BITS-1:2], 2'b00};
      // Buffered plus outstanding entries form the credit pool, so a
      // returning response always finds a free queue slot.
      occupancy = {1'b0, count_q} + {1'b0, inflight_q};
      req       = !reset && !bus.redirect_valid && (occupancy < DEPTH_LIM);
      accept    = req && bus.i_mem_ready;
      // Responses with nothing outstanding are protocol violations: ignored.
      resp      = bus.i_mem_valid && (inflight_q != '0);
      ivalid    = (count_q != '0) && !bus.redirect_valid;
      pop       = ivalid && bus.issue_ready;
      push      = resp && (drop_count_q == '0) && !bus.redirect_valid;

      fetch_pc_d   = fetch_pc_q;
      resp_pc_d    = resp_pc_q;
      inflight_d   = inflight_q;
      drop_count_d = drop_count_q;
      count_d      = count_q;
      head_d       = head_q;
      tail_d       = tail_q;

      if (bus.redirect_valid) begin
         // Everything still outstanding is wrong-path, including nothing of
         // the response consumed in this very cycle.
         fetch_pc_d   = redirect_target;
         resp_pc_d    = redirect_target;
         inflight_d   = inflight_q - CW'(resp);
         drop_count_d = inflight_q - CW'(resp);
         count_d      = '0;
         head_d       = '0;
         tail_d       = '0;
      end else begin
         if (accept) begin
            fetch_pc_d = fetch_pc_q + ADDRESS_BITS'(4);
         end
         inflight_d = inflight_q + CW'(accept) - CW'(resp);
         if (resp && (drop_count_q != '0)) begin
            drop_count_d = drop_count_q - CW'(1);
         end
         if (push) begin
            resp_pc_d = resp_pc_q + ADDRESS_BITS'(4);
            tail_d    = tail_q + PW'(1);
         end
         if (pop) begin
            head_d = head_q + PW'(1);
         end
         count_d = count_q + CW'(push) - CW'(pop);
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         fetch_pc_q   <= RESET_PC;
         resp_pc_q    <= RESET_PC;
         inflight_q   <= '0;
         drop_count_q <= '0;
         count_q      <= '0;
         head_q       <= '0;
         tail_q       <= '0;
      end else begin
         fetch_pc_q   <= fetch_pc_d;
         resp_pc_q    <= resp_pc_d;
         inflight_q   <= inflight_d;
         drop_count_q <= drop_count_d;
         count_q      <= count_d;
         head_q       <= head_d;
         tail_q       <= tail_d;
      end
   end

   always_ff @(posedge clock) begin
      if (push) begin
         pc_mem[tail_q]  <= resp_pc_q;
         ins_mem[tail_q] <= bus.i_mem_data;
      end
   end

   assign bus.i_mem_read         = req;
   assign bus.i_mem_read_address = fetch_pc_q;
   assign bus.issue_valid        = ivalid;
   assign bus.issue_PC           = ivalid ? pc_mem[head_q]  : '0;
   assign bus.issue_instruction  = ivalid ? ins_mem[head_q] : '0;
endmodule

// File: tb/tb_fetch_queue_issue.sv
// tb_fetch_queue_issue
//   Self-checking bench: a memory model with configurable latency answers
//   requests; a queue-based reference model of the fetch stage predicts
//   every output each cycle; directed phases pin literal expectations.
module tb_fetch_queue_issue;
   localparam int unsigned DEPTH = 4;
   localparam logic [31:0] RPC   = 32'h0;

   typedef struct { logic [31:0] addr; logic doomed; } req_t;
   typedef struct { logic [31:0] pc;   logic [31:0] ins; } ent_t;
   typedef struct { logic [31:0] addr; int unsigned due; } mreq_t;

   logic clock = 1'b0;
   logic reset;
   logic scan;

   fetch_queue_issue_if #(.ADDRESS_BITS(32), .DATA_WIDTH(32)) bus ();

   fetch_queue_issue #(
      .ADDRESS_BITS(32),
      .DATA_WIDTH  (32),
      .QUEUE_DEPTH (DEPTH),
      .RESET_PC    (RPC)
   ) dut (
      .clock(clock),
      .reset(reset),
      .scan (scan),
      .bus  (bus)
   );

   always #5 clock = ~clock;

   int unsigned tests = 0;
   int unsigned fails = 0;
   int unsigned cyc   = 0;
   logic        started = 1'b0;

   // reference model state
   req_t        outq[$];
   ent_t        iq[$];
   logic [31:0] exp_fetch = RPC;
   // memory model
   mreq_t       mq[$];
   // logs of DUT handshakes
   logic [31:0] acc_addr[$];
   int unsigned acc_cyc[$];
   logic [31:0] iss_pc[$];
   logic [31:0] iss_ins[$];
   int unsigned iss_cyc[$];
   // sampled outputs of the last cycle
   logic        s_read, s_ivalid;
   logic [31:0] s_addr, s_pc, s_ins;
   // knobs
   logic        k_rst = 1'b1, k_redir = 1'b0, k_mready = 1'b1, k_iready = 1'b1;
   logic        k_force_spur = 1'b0, k_rand = 1'b0;
   logic [31:0] k_rpc = '0;
   int unsigned k_lat = 1;

   function automatic logic [31:0] memf(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
   endfunction

   task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic clear_logs();
      acc_addr.delete(); acc_cyc.delete();
      iss_pc.delete(); iss_ins.delete(); iss_cyc.delete();
   endtask

   task automatic cycle();
      logic        from_mq;
      logic        e_read, e_iv;
      logic [31:0] e_pc, e_ins;
      req_t        r;
      @(negedge clock);
      reset              = k_rst;
      scan               = $urandom_range(0, 1) == 0;
      bus.redirect_valid = k_redir;
      bus.redirect_PC    = k_rpc;
      bus.i_mem_ready    = k_mready;
      bus.issue_ready    = k_iready;
      from_mq            = 1'b0;
      bus.i_mem_valid    = 1'b0;
      bus.i_mem_data     = '0;
      if (mq.size() > 0 && mq[0].due <= cyc && !(k_rand && $urandom_range(0, 4) == 0)) begin
         bus.i_mem_valid = 1'b1;
         bus.i_mem_data  = memf(mq[0].addr);
         from_mq         = 1'b1;
      end else if (mq.size() == 0 && (k_force_spur || (k_rand && $urandom_range(0, 9) == 0))) begin
         bus.i_mem_valid = 1'b1;
         bus.i_mem_data  = $urandom;
      end
      #1;
      e_read = !reset && !bus.redirect_valid && (iq.size() + outq.size() < DEPTH);
      e_iv   = (iq.size() != 0) && !bus.redirect_valid;
      e_pc   = e_iv ? iq[0].pc  : 32'h0;
      e_ins  = e_iv ? iq[0].ins : 32'h0;
      s_read = bus.i_mem_read; s_addr = bus.i_mem_read_address;
      s_ivalid = bus.issue_valid; s_pc = bus.issue_PC; s_ins = bus.issue_instruction;
      if (started) begin
         cmp("i_mem_read", {63'b0, s_read}, {63'b0, e_read});
         cmp("i_mem_read_address", {32'b0, s_addr}, {32'b0, exp_fetch});
         cmp("issue_valid", {63'b0, s_ivalid}, {63'b0, e_iv});
         cmp("issue_PC", {32'b0, s_pc}, {32'b0, e_pc});
         cmp("issue_instruction", {32'b0, s_ins}, {32'b0, e_ins});
      end
      // handshake logs and memory side, driven by what the DUT actually does
      if (s_read === 1'b1 && bus.i_mem_ready) begin
         acc_addr.push_back(s_addr); acc_cyc.push_back(cyc);
      end
      if (s_ivalid === 1'b1 && bus.issue_ready) begin
         iss_pc.push_back(s_pc); iss_ins.push_back(s_ins); iss_cyc.push_back(cyc);
      end
      if (from_mq) void'(mq.pop_front());
      if (reset) mq.delete();
      else if (s_read === 1'b1 && bus.i_mem_ready)
         mq.push_back('{addr: s_addr, due: cyc + k_lat});
      // reference model update
      if (reset) begin
         outq.delete(); iq.delete(); exp_fetch = RPC;
      end else if (bus.redirect_valid) begin
         if (bus.i_mem_valid && outq.size() > 0) void'(outq.pop_front());
         foreach (outq[i]) outq[i].doomed = 1'b1;
         iq.delete();
         exp_fetch = {bus.redirect_PC[31:2], 2'b00};
      end else begin
         if (iq.size() > 0 && bus.issue_ready) void'(iq.pop_front());
         if (bus.i_mem_valid && outq.size() > 0) begin
            r = outq.pop_front();
            if (!r.doomed) iq.push_back('{pc: r.addr, ins: bus.i_mem_data});
         end
         if (e_read && bus.i_mem_ready) begin
            outq.push_back('{addr: exp_fetch, doomed: 1'b0});
            exp_fetch = exp_fetch + 32'd4;
         end
      end
      if (reset) started = 1'b1;
      @(posedge clock);
      #1;
      cyc++;
   endtask

   task automatic do_reset(input int unsigned n);
      k_rst = 1'b1; k_redir = 1'b0; k_force_spur = 1'b0;
      repeat (n) cycle();
      k_rst = 1'b0;
   endtask

   task automatic check_reset_outputs(input string tag);
      cmp({tag, "_read"}, {63'b0, bus.i_mem_read}, 64'd0);
      cmp({tag, "_addr"}, {32'b0, bus.i_mem_read_address}, {32'b0, RPC});
      cmp({tag, "_ivalid"}, {63'b0, bus.issue_valid}, 64'd0);
      cmp({tag, "_pc"}, {32'b0, bus.issue_PC}, 64'd0);
      cmp({tag, "_ins"}, {32'b0, bus.issue_instruction}, 64'd0);
   endtask

   initial begin
      reset = 1'b1; scan = 1'b0;
      bus.redirect_valid = 1'b0; bus.redirect_PC = '0; bus.i_mem_ready = 1'b0;
      bus.i_mem_valid = 1'b0; bus.i_mem_data = '0; bus.issue_ready = 1'b0;

      // sequential fetch
      do_reset(2);
      check_reset_outputs("reset");
      clear_logs();
      k_lat = 1; k_mready = 1'b1; k_iready = 1'b1;
      cycle();
      cmp("first_read", {63'b0, s_read}, 64'd1);
      cmp("first_addr", {32'b0, s_addr}, {32'b0, RPC});
      repeat (11) cycle();
      cmp("seq_acc_count", {63'b0, acc_addr.size() >= 5}, 64'd1);
      for (int i = 0; i < 5; i++) begin
         cmp("seq_addr", {32'b0, acc_addr[i]}, 64'(4 * i));
         cmp("seq_addr_cycle", 64'(acc_cyc[i]), 64'(acc_cyc[0] + i));
      end
      cmp("seq_iss_count", {63'b0, iss_pc.size() >= 3}, 64'd1);
      cmp("seq_iss_pc0", {32'b0, iss_pc[0]}, 64'h0);
      cmp("seq_iss_pc1", {32'b0, iss_pc[1]}, 64'h4);
      cmp("seq_iss_pc2", {32'b0, iss_pc[2]}, 64'h8);
      cmp("seq_iss_cycle", 64'(iss_cyc[0]), 64'(acc_cyc[0] + 2));
      cmp("seq_iss_ins0", {32'b0, iss_ins[0]}, {32'b0, memf(32'h0)});
      cmp("seq_iss_ins2", {32'b0, iss_ins[2]}, {32'b0, memf(32'h8)});

      // backpressure
      do_reset(1);
      clear_logs();
      k_iready = 1'b0;
      repeat (10) cycle();
      cmp("bp_accepts", 64'(acc_addr.size()), 64'd4);
      cmp("bp_read_low", {63'b0, bus.i_mem_read}, 64'd0);
      cmp("bp_model_count", 64'(iq.size()), 64'd4);
      k_iready = 1'b1;
      clear_logs();
      repeat (8) cycle();
      cmp("bp_iss_count", {63'b0, iss_pc.size() >= 4}, 64'd1);
      for (int i = 0; i < 4; i++) cmp("bp_iss_pc", {32'b0, iss_pc[i]}, 64'(4 * i));
      cmp("bp_resume_addr", {32'b0, acc_addr[0]}, 64'h10);

      // redirect with outstanding requests
      do_reset(1);
      clear_logs();
      k_lat = 3;
      repeat (3) cycle();
      cmp("rd_inflight_accepts", 64'(acc_addr.size()), 64'd3);
      k_redir = 1'b1; k_rpc = 32'h8000;
      cycle();
      cmp("rd_no_read", {63'b0, s_read}, 64'd0);
      k_redir = 1'b0;
      clear_logs();
      cycle();
      cmp("rd_next_addr", {32'b0, s_addr}, 64'h8000);
      repeat (14) cycle();
      cmp("rd_iss_nonempty", {63'b0, iss_pc.size() > 0}, 64'd1);
      cmp("rd_first_iss", {32'b0, iss_pc[0]}, 64'h8000);
      cmp("rd_first_ins", {32'b0, iss_ins[0]}, {32'b0, memf(32'h8000)});

      // simultaneous redirect, response and issue_ready with count = 2
      do_reset(1);
      clear_logs();
      k_lat = 2; k_iready = 1'b0;
      repeat (4) cycle();
      cmp("sim_count_before", 64'(dut.count_q), 64'd2);
      k_redir = 1'b1; k_rpc = 32'h200; k_iready = 1'b1;
      cycle();
      cmp("sim_no_issue", {63'b0, s_ivalid}, 64'd0);
      cmp("sim_iss_log", 64'(iss_pc.size()), 64'd0);
      cmp("sim_count_after", 64'(dut.count_q), 64'd0);
      cmp("sim_drop_count", 64'(dut.drop_count_q), 64'd1);
      cmp("sim_model_doomed", {62'b0, outq.size() == 1, outq[0].doomed}, 64'd3);
      k_redir = 1'b0;
      repeat (8) cycle();

      // memory stall then redirect near the top of the address space
      do_reset(1);
      clear_logs();
      k_mready = 1'b0; k_lat = 1;
      repeat (5) begin
         cycle();
         cmp("stall_addr", {32'b0, s_addr}, 64'h0);
         cmp("stall_read", {63'b0, s_read}, 64'd1);
      end
      cmp("stall_no_accept", 64'(acc_addr.size()), 64'd0);
      k_redir = 1'b1; k_rpc = 32'hFFFF_FFF8;
      cycle();
      k_redir = 1'b0; k_mready = 1'b1;
      clear_logs();
      repeat (10) cycle();
      cmp("wrap_iss_count", {63'b0, iss_pc.size() >= 3}, 64'd1);
      cmp("wrap_pc0", {32'b0, iss_pc[0]}, 64'hFFFF_FFF8);
      cmp("wrap_pc1", {32'b0, iss_pc[1]}, 64'hFFFF_FFFC);
      cmp("wrap_pc2", {32'b0, iss_pc[2]}, 64'h0);

      // misaligned redirect, then reset mid-stream
      k_lat = 3; k_redir = 1'b1; k_rpc = 32'h1003;
      cycle();
      k_redir = 1'b0;
      clear_logs();
      cycle();
      cmp("mis_addr", {32'b0, s_addr}, 64'h1000);
      repeat (6) cycle();
      cmp("mis_first_iss", {32'b0, iss_pc[0]}, 64'h1000);
      k_rst = 1'b1;
      cycle();
      check_reset_outputs("midrst");
      k_rst = 1'b0;
      k_force_spur = 1'b1;
      clear_logs();
      cycle();
      k_force_spur = 1'b0;
      cmp("midrst_read", {63'b0, s_read}, 64'd1);
      cmp("midrst_addr", {32'b0, s_addr}, {32'b0, RPC});
      repeat (8) cycle();
      cmp("midrst_first_iss", {32'b0, iss_pc[0]}, {32'b0, RPC});
      cmp("midrst_first_ins", {32'b0, iss_ins[0]}, {32'b0, memf(RPC)});

      // randomized traffic
      k_rand = 1'b1;
      for (int n = 0; n < 3000; n++) begin
         if ($urandom_range(0, 49) == 0) k_lat = $urandom_range(1, 4);
         k_mready = $urandom_range(0, 3) != 0;
         k_iready = $urandom_range(0, 2) != 0;
         k_redir  = $urandom_range(0, 40) == 0;
         k_rpc    = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                                : $urandom;
         k_rst    = $urandom_range(0, 300) == 0;
         cycle();
      end
      k_rand = 1'b0; k_rst = 1'b0; k_redir = 1'b0;

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
